// File: rtl/muldiv_seq_if.sv
// Execute-stage bus between the pipeline and the multi-cycle multiply/divide unit.
`timescale 1ns/1ps

// start is a one-cycle request sampled with funct/a/b only while busy is low;
// requests seen while busy is high are dropped. done pulses for exactly one cycle
// when hi/lo take a mult/div result. flush aborts a running op and wins over start.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, funct, a, b, flush,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, funct, a, b, flush,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider holding the MIPS HI/LO registers.
// Define MULDIV_SIGNED_EN for signed mult/div; otherwise they behave as multu/divu.
`timescale 1ns/1ps

module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus,
  output logic [1:0]  state_o
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic             start_mul, start_div, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_res, neg_rem;

  assign start_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign start_div = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign accept    = (state_q != S_RUN) && bus.start && !bus.flush && (start_mul || start_div);

`ifdef MULDIV_SIGNED_EN
  logic op_signed, a_neg, b_neg;
  logic neg_res_q, neg_rem_q;

  assign op_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign a_neg     = op_signed & bus.a[WIDTH-1];
  assign b_neg     = op_signed & bus.b[WIDTH-1];
  assign mag_a     = a_neg ? -bus.a : bus.a;
  assign mag_b     = b_neg ? -bus.b : bus.b;

  // neg_res: sign of product/quotient; neg_rem: sign of remainder (follows a)
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end
  end

  assign neg_res = neg_res_q;
  assign neg_rem = neg_rem_q;
`else
  assign mag_a   = bus.a;
  assign mag_b   = bus.b;
  assign neg_res = 1'b0;
  assign neg_rem = 1'b0;
`endif

  // multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // divide: acc = {remainder, dividend bits becoming quotient}, shifted left each step
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] iter_next;
  assign iter_next = is_div_q ? div_next : mul_next;

  logic               div_by_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  assign div_by_zero = (opb_q == '0);
  assign prod_fix    = neg_res ? -iter_next : iter_next;
  assign quo         = iter_next[WIDTH-1:0];
  assign rem         = iter_next[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div_by_zero) begin
        // restoring the sign of the stored magnitude gives back the original a bits
        res_lo = '1;
        res_hi = neg_rem ? -opa_q : opa_q;
      end else begin
        res_lo = neg_res ? -quo : quo;
        res_hi = neg_rem ? -rem : rem;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = iter_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIN;
            hi_d    = res_hi;
            lo_d    = res_lo;
            if (is_div_q) dz_d = div_by_zero;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = start_div;
          opa_d    = mag_a;
          opb_d    = mag_b;
          acc_d    = start_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        end else if (bus.start && !bus.flush) begin
          if (bus.funct == F_MTHI) hi_d = bus.a;
          if (bus.funct == F_MTLO) lo_d = bus.a;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_FIN);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq with an arithmetic reference model and scoreboard.
`timescale 1ns/1ps

module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_o;

  muldiv_seq_if #(.WIDTH(W)) bus();

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_e;
  logic [W-1:0] m_hi, m_lo;
  logic         m_dz;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // returns {hi, lo, div_zero} after the operation completes
  function automatic logic [2*W:0] ref_op(input logic [5:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    bit sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = (f == F_MULT) || (f == F_DIV);
`else
    sgn = 1'b0;
`endif
    sa = $signed(a);
    sb = $signed(b);
    if ((f == F_MULT) || (f == F_MULTU)) begin
      if (sgn) p = sa * sb;
      else     p = {32'b0, a} * {32'b0, b};
      return {p[63:32], p[31:0], dz};
    end
    if (b == '0) return {a, {W{1'b1}}, 1'b1};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0], 1'b0};
    end
    return {a % b, a / b, 1'b0};
  endfunction

  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit expect_it);
    logic [2*W:0] r;
    bus.start = 1'b1;
    bus.funct = f;
    bus.a     = a;
    bus.b     = b;
    if (expect_it) begin
      if (is_muldiv(f)) begin
        r = ref_op(f, a, b, m_dz);
        exp_q.push_back(r);
        {m_hi, m_lo, m_dz} = r;
      end else if (f == F_MTHI) begin
        m_hi = a;
      end else if (f == F_MTLO) begin
        m_lo = a;
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // leaves the caller at the negedge of the done cycle
  task automatic wait_done(input string name, input int exp_lat);
    int busy_n = 0;
    int lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        chk({name, " busy_at_done"}, bus.busy, 0);
        break;
      end
      if (bus.busy) busy_n++;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " busy_cycles"}, busy_n, exp_lat - 1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: hi=%0h lo=%0h with no pending op", bus.hi, bus.lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("scoreboard {hi,lo,dz}", {bus.hi, bus.lo, bus.div_zero}, mon_e);
      end
    end
  end

  initial begin
    logic [5:0] ftab [6];
    logic [5:0] f;
    logic [W-1:0] ra, rb;
    int seen;
    ftab[0] = F_MULT; ftab[1] = F_MULTU; ftab[2] = F_DIV;
    ftab[3] = F_DIVU; ftab[4] = F_MTHI;  ftab[5] = F_MTLO;
    bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset div_zero", bus.div_zero, 0);
    chk("reset state", state_o, 0);
    rst = 1'b0;
    @(negedge clk);

    start_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_done("multu max", W + 1);
    chk("multu max hi", bus.hi, 32'hFFFFFFFE);
    chk("multu max lo", bus.lo, 32'h00000001);
    @(negedge clk);

    start_op(F_MULT, -32'sd3, 32'd7, 1);
    wait_done("mult -3*7", W + 1);
`ifdef MULDIV_SIGNED_EN
    chk("mult -3*7 hi", bus.hi, 32'hFFFFFFFF);
`else
    chk("mult -3*7 hi", bus.hi, 32'h00000006);
`endif
    chk("mult -3*7 lo", bus.lo, 32'hFFFFFFEB);
    @(negedge clk);

    start_op(F_DIV, -32'sd7, 32'd2, 1);
    wait_done("div -7/2", W + 1);
    @(negedge clk);
    start_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_done("div min/-1", W + 1);
`ifdef MULDIV_SIGNED_EN
    chk("div min/-1 lo", bus.lo, 32'h80000000);
    chk("div min/-1 hi", bus.hi, 32'h0);
`endif
    @(negedge clk);

    start_op(F_DIVU, 32'd100, 32'd0, 1);
    wait_done("divu 100/0", W + 1);
    chk("divu 100/0 lo", bus.lo, 32'hFFFFFFFF);
    chk("divu 100/0 hi", bus.hi, 32'd100);
    chk("divu 100/0 dz", bus.div_zero, 1);
    @(negedge clk);
    start_op(F_DIVU, 32'd100, 32'd7, 1);
    wait_done("divu 100/7", W + 1);
    chk("divu 100/7 lo", bus.lo, 32'd14);
    chk("divu 100/7 hi", bus.hi, 32'd2);
    chk("divu 100/7 dz", bus.div_zero, 0);
    @(negedge clk);

    // flush at cycle t+10
    start_op(F_MULT, 32'd5, 32'd6, 0);
    repeat (10) @(negedge clk);
    chk("flush busy before", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush busy after", bus.busy, 0);
    chk("flush state", state_o, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("flush no done", seen, 0);
    chk("flush hi kept", bus.hi, m_hi);
    chk("flush lo kept", bus.lo, m_lo);

    start_op(F_MTLO, 32'h1234, 32'h0, 1);
    @(negedge clk);
    chk("mtlo lo", bus.lo, 32'h1234);
    chk("mtlo busy", bus.busy, 0);
    chk("mtlo done", bus.done, 0);

    bus.flush = 1'b1;
    start_op(F_MULTU, 32'd3, 32'd4, 0);
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush+start dropped", bus.busy, 0);

    // a start during RUN must be ignored
    start_op(F_MULTU, 32'd9, 32'd9, 1);
    repeat (5) @(negedge clk);
    start_op(F_DIVU, 32'd1, 32'd1, 0);
    wait_done("start in run", W + 1 - 5);
    @(negedge clk);

    start_op(F_MULTU, 32'hDEADBEEF, 32'h12345, 1);
    wait_done("b2b first", W + 1);
    start_op(F_MULTU, 32'hCAFEF00D, 32'h777, 1);
    wait_done("b2b second", W + 1);
    @(negedge clk);

    start_op(F_MULTU, 32'h1234, 32'h5678, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst in run hi", bus.hi, 0);
    chk("rst in run lo", bus.lo, 0);
    chk("rst in run busy", bus.busy, 0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      f  = ftab[$urandom_range(0, 5)];
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = '1; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 255);
        default: ;
      endcase
      start_op(f, ra, rb, 1);
      if (is_muldiv(f)) begin
        wait_done("random op", W + 1);
      end else begin
        @(negedge clk);
        chk("random move hi", bus.hi, m_hi);
        chk("random move lo", bus.lo, m_lo);
        chk("random move done", bus.done, 0);
      end
      @(negedge clk);
    end

    @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised multi-cycle multiply/divide unit for the MIPS execute stage; sits beside the single-cycle ALU.
- Decodes its own R-type funct, runs an iterative shift-add multiply or restoring divide, and holds the architectural HI/LO registers.
- Stalls the pipeline through a start/busy/done handshake.
- Adds mult/multu/div/divu/mthi/mtlo on top of the existing add/sub/and/or/slt ALU decode.

Parameters:
- WIDTH, 32, operand width and HI/LO width; any even value >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled with funct/a/b.
- funct  input  6  R-type funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
- a  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort in-flight operation.
- busy  output  1  operation in progress; pipeline stall.
- done  output  1  one-cycle pulse; HI/LO just updated by mult/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- div_zero  output  1  sticky flag; last completed div/divu had b == 0.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, div_zero 0, counter 0. Reset mid-operation aborts immediately with the same values.
- FSM states: IDLE, RUN, FIN.
- IDLE or FIN, start=1, funct = mult/multu/div/divu:
  - Latch operands; for signed ops, convert to magnitudes and record result signs.
  - Go to RUN with counter = 0.
- IDLE or FIN, start=1, funct = mthi/mtlo:
  - Write a into hi/lo at that edge.
  - No busy, no done; next state IDLE.
- start with any other funct: ignored, state IDLE. start while in RUN: ignored; no queueing.
- RUN: one iteration per cycle, counter increments. After WIDTH iterations go to FIN.
- FIN:
  - Lasts one cycle; done = 1.
  - hi/lo show the final result from this cycle on.
  - A new start is accepted in FIN.
  - Without a new start, next state IDLE.
- Latency:
  - start accepted at edge t; busy = 1 for cycles t+1 .. t+WIDTH.
  - done = 1 in cycle t+WIDTH+1, with busy = 0 in that cycle.
  - hi/lo are updated only at the FIN-entry edge; intermediate values never appear on hi/lo.
- Multiply:
  - Full 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Signed result = two's-complement negation of the unsigned magnitude product when the sign bits of a and b differ.
- Divide:
  - lo = quotient, hi = remainder.
  - Signed: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); truncation toward zero.
  - Signed a = -2^(WIDTH-1), b = -1: lo = -2^(WIDTH-1), hi = 0, no trap.
- Divide by zero:
  - Iteration still runs full length.
  - Result forced to lo = all ones, hi = a (original, unsigned bits); div_zero set at FIN.
  - div_zero is cleared at FIN of any div/divu with b != 0; mult does not change it.
- flush:
  - In RUN: next state IDLE, busy drops next cycle, no done, hi/lo/div_zero unchanged.
  - flush together with start in IDLE/FIN: start is dropped.
  - flush has priority over start; rst has priority over everything.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined: mult/div are signed as described above.
- Undefined:
  - mult and div are executed exactly as multu and divu; no sign/magnitude logic is synthesised.
  - Divide-by-zero and all other timing are identical.

Test Plan (WIDTH=32):
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> done at t+33; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 32 cycles.
- mult (signed build), a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Unsigned build: same stimulus -> hi=0x00000006, lo=0xFFFFFFEB.
- div (signed build), a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu, a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1. A following divu 100/7 -> lo=14, hi=2, div_zero=0.
- mult started, flush at cycle t+10 -> busy low at t+11, no done, hi/lo keep prior values. Then mtlo a=0x1234 -> lo=0x1234 next cycle, no done.
- start with new multu in FIN cycle -> back-to-back done pulses 33 cycles apart. rst asserted in RUN -> hi=lo=0, busy=0 next cycle.
